cordic_pipe_arbiter: RTL and testbench

Shares one pipelined CORDIC rotator (a chain of `STAGES` rotation stages with a common `enabled` input) between two requesters. Grants issue slots round-robin, tracks each in-flight operand with a valid/tag shift register aligned to the pipeline, and routes each result back to its owner. The pipeline stalls globally when the result at its tail is not accepted.

---
 rtl/cordic_pipe_arbiter.sv | 106 ++++++++++
 tb/tb_cordic_pipe_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_arbiter.sv
// Round-robin issue arbiter for a shared, globally stalled CORDIC rotation pipeline.
// A valid/tag shadow register tracks each operand so its result returns to the requester that issued it.
module cordic_pipe_arbiter #(
  parameter int NUM_WIDTH = 24,
  parameter int STAGES    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [3*NUM_WIDTH-1:0]        req0_data,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [3*NUM_WIDTH-1:0]        req1_data,
  output logic                          pipe_en,
  output logic signed [NUM_WIDTH-1:0]   pipe_x,
  output logic signed [NUM_WIDTH-1:0]   pipe_y,
  output logic signed [NUM_WIDTH-1:0]   pipe_z,
  input  logic signed [NUM_WIDTH-1:0]   pipe_ox,
  input  logic signed [NUM_WIDTH-1:0]   pipe_oy,
  input  logic signed [NUM_WIDTH-1:0]   pipe_oz,
  output logic                          resp0_valid,
  input  logic                          resp0_ready,
  output logic [3*NUM_WIDTH-1:0]        resp0_data,
  output logic                          resp1_valid,
  input  logic                          resp1_ready,
  output logic [3*NUM_WIDTH-1:0]        resp1_data,
  output logic                          busy
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] tag;
  logic              last;

  logic tail_vld;
  logic tail_tag;
  logic tail_ready;
  logic win0;
  logic win1;
  logic grant0;
  logic grant1;
  logic any_grant;
  logic grant_id;

  assign tail_vld   = vld[STAGES-1];
  assign tail_tag   = tag[STAGES-1];
  // Only the owner's ready can retire the tail; a bubble at the tail never stalls.
  assign tail_ready = tail_tag ? resp1_ready : resp0_ready;
  assign pipe_en    = ~tail_vld | tail_ready;

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (req0_valid && req1_valid) begin
      win0 = last;
      win1 = ~last;
    end else begin
      win0 = req0_valid;
      win1 = req1_valid;
    end
  end

  assign grant0     = win0 & pipe_en;
  assign grant1     = win1 & pipe_en;
  assign any_grant  = grant0 | grant1;
  assign grant_id   = grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    pipe_x = '0;
    pipe_y = '0;
    pipe_z = '0;
    if (grant0) begin
      {pipe_x, pipe_y, pipe_z} = req0_data;
    end else if (grant1) begin
      {pipe_x, pipe_y, pipe_z} = req1_data;
    end
  end

  // Shadow of the rotation stages: entry i holds the owner of stage i's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      tag  <= '0;
      last <= 1'b1;
    end else if (pipe_en) begin
      vld[0] <= any_grant;
      tag[0] <= grant_id;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      if (any_grant) begin
        last <= grant_id;
      end
    end
  end

  assign resp0_valid = tail_vld & ~tail_tag;
  assign resp1_valid = tail_vld & tail_tag;
  assign resp0_data  = {pipe_ox, pipe_oy, pipe_oz};
  assign resp1_data  = {pipe_ox, pipe_oy, pipe_oz};
  assign busy        = |vld;

endmodule

// File: tb/tb_cordic_pipe_arbiter.sv
// Directed bench for cordic_pipe_arbiter; a pass-through register chain stands in for the rotation stages.
module tb_cordic_pipe_arbiter;
  localparam int NW = 24;
  localparam int ST = 16;
  localparam int PW = 3*NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [PW-1:0] req0_data, req1_data;
  logic          pipe_en;
  logic signed [NW-1:0] pipe_x, pipe_y, pipe_z;
  logic signed [NW-1:0] pipe_ox, pipe_oy, pipe_oz;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready, resp1_ready;
  logic [PW-1:0] resp0_data, resp1_data;
  logic          busy;

  logic [ST-1:0][PW-1:0] chain;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int            exp_id [8];
  logic [PW-1:0] exp_d  [8];

  always #5 clk = ~clk;

  cordic_pipe_arbiter #(.NUM_WIDTH(NW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .pipe_en(pipe_en), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z),
    .pipe_ox(pipe_ox), .pipe_oy(pipe_oy), .pipe_oz(pipe_oz),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .busy(busy)
  );

  // Stand-in stage chain sharing rst and the enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else if (pipe_en) chain <= {chain[ST-2:0], pipe_x, pipe_y, pipe_z};
  end
  assign pipe_ox = chain[ST-1][3*NW-1:2*NW];
  assign pipe_oy = chain[ST-1][2*NW-1:NW];
  assign pipe_oz = chain[ST-1][NW-1:0];

  function automatic logic [PW-1:0] mk(input int id, input int k);
    logic [NW-1:0] x;
    x = (id == 1 ? 24'hA00000 : 24'h500000) + NW'(k);
    return {x, ~x, x ^ 24'h0F0F0F};
  endfunction

  task automatic chk(input string tg, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tg, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    resp0_ready = 1; resp1_ready = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pipe_en", pipe_en, 1);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pipe_xyz", {pipe_x, pipe_y, pipe_z}, '0);
    rst = 1'b0;
    cyc = 0;

    // Single op accepted in cycle 5, result in cycle 21
    while (cyc < 4) next_cycle();
    next_cycle();
    req0_valid = 1; req0_data = {24'h4DBA76, 24'h000000, 24'h200000};
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    chk("single_issue", {pipe_x, pipe_y, pipe_z}, {24'h4DBA76, 24'h000000, 24'h200000});
    while (cyc < 30) begin
      next_cycle();
      req0_valid = 0;
      #1;
      chk("single_resp0_valid", resp0_valid, (cyc == 21) ? 1 : 0);
      chk("single_resp1_valid", resp1_valid, 0);
      if (cyc == 21) chk("single_resp0_data", resp0_data, {24'h4DBA76, 24'h000000, 24'h200000});
      if (cyc == 6)  chk("single_busy", busy, 1);
      if (cyc == 22) chk("single_idle", busy, 0);
    end

    // Contention cycles 31..38; last grant was req0, so req1 goes first
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req0_valid = 1; req1_valid = 1;
      req0_data = mk(0, k); req1_data = mk(1, k);
      #1;
      exp_id[k] = (k % 2 == 0) ? 1 : 0;
      exp_d[k]  = mk(exp_id[k], k);
      chk("cont_req0_ready", req0_ready, (exp_id[k] == 0) ? 1 : 0);
      chk("cont_req1_ready", req1_ready, (exp_id[k] == 1) ? 1 : 0);
      chk("cont_issue", {pipe_x, pipe_y, pipe_z}, exp_d[k]);
    end
    while (cyc < 56) begin
      next_cycle();
      req0_valid = 0; req1_valid = 0;
      #1;
      if (cyc >= 47 && cyc <= 54) begin
        chk("cont_resp0_valid", resp0_valid, (exp_id[cyc-47] == 0) ? 1 : 0);
        chk("cont_resp1_valid", resp1_valid, (exp_id[cyc-47] == 1) ? 1 : 0);
        chk("cont_resp_data", (exp_id[cyc-47] == 0) ? resp0_data : resp1_data, exp_d[cyc-47]);
      end else begin
        chk("cont_gap_valid", {resp0_valid, resp1_valid}, 0);
      end
    end

    // Backpressure: 4 ops from req1 at cycles 60..63, results held 3 cycles at 76..78
    while (cyc < 59) next_cycle();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req1_valid = 1; req1_data = mk(1, 16 + k);
      #1;
      chk("bp_req1_ready", req1_ready, 1);
    end
    while (cyc < 82) begin
      next_cycle();
      req1_valid = 0; req0_valid = 0;
      if (cyc >= 76 && cyc <= 78) begin
        resp1_ready = 0; req0_valid = 1; req1_valid = 1;
      end else begin
        resp1_ready = 1;
      end
      #1;
      if (cyc >= 76 && cyc <= 78) begin
        chk("bp_pipe_en", pipe_en, 0);
        chk("bp_ready", {req0_ready, req1_ready}, 0);
        chk("bp_hold_valid", resp1_valid, 1);
        chk("bp_hold_data", resp1_data, mk(1, 16));
      end else if (cyc >= 79) begin
        chk("bp_resp1_valid", resp1_valid, 1);
        chk("bp_resp1_data", resp1_data, mk(1, 16 + cyc - 79));
        chk("bp_pipe_en_run", pipe_en, 1);
      end else begin
        chk("bp_early_valid", resp1_valid, 0);
      end
    end
    next_cycle();
    #1;
    chk("bp_drained", busy, 0);

    // Wrong-owner ready: op from req0 at 85 reaches the tail at 101
    next_cycle();
    next_cycle();
    req0_valid = 1; req0_data = mk(0, 20);
    #1;
    chk("wo_req0_ready", req0_ready, 1);
    while (cyc < 104) begin
      next_cycle();
      req0_valid = 0;
      resp0_ready = (cyc >= 104) ? 1 : 0;
      resp1_ready = 1;
      #1;
      if (cyc <= 100) chk("wo_bubble_pipe_en", pipe_en, 1);
      else if (cyc <= 103) begin
        chk("wo_stall_pipe_en", pipe_en, 0);
        chk("wo_resp0_valid", resp0_valid, 1);
        chk("wo_resp1_valid", resp1_valid, 0);
      end else begin
        chk("wo_retire_valid", resp0_valid, 1);
        chk("wo_retire_data", resp0_data, mk(0, 20));
        chk("wo_retire_pipe_en", pipe_en, 1);
      end
    end
    next_cycle();
    #1;
    chk("wo_drained", busy, 0);

    // Bubbles: req0 at 107,109,111,113 with resp0_ready low until 123
    resp0_ready = 0;
    while (cyc < 130) begin
      next_cycle();
      req0_valid = (cyc >= 107 && cyc <= 113 && (cyc % 2 == 1)) ? 1 : 0;
      req0_data  = mk(0, 30 + (cyc - 107) / 2);
      resp0_ready = (cyc >= 123) ? 1 : 0;
      #1;
      if (req0_valid) chk("bub_req0_ready", req0_ready, 1);
      if (cyc <= 122) chk("bub_pipe_en", pipe_en, 1);
      if (cyc >= 123) begin
        chk("bub_resp0_valid", resp0_valid, (cyc <= 129 && (cyc % 2 == 1)) ? 1 : 0);
        if (cyc <= 129 && (cyc % 2 == 1))
          chk("bub_resp0_data", resp0_data, mk(0, 30 + (cyc - 123) / 2));
      end
    end

    // Reset with 6 ops in flight; the first contention afterwards goes to req0
    resp0_ready = 1; resp1_ready = 1;
    while (cyc < 131) next_cycle();
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      req0_valid = 1; req1_valid = 1;
      req0_data = mk(0, 40 + k); req1_data = mk(1, 40 + k);
    end
    next_cycle();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("rr_busy_before", busy, 1);
    while (cyc < 140) next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rr_async_busy", busy, 0);
    chk("rr_async_pipe_en", pipe_en, 1);
    next_cycle();
    rst = 1'b0;
    while (cyc < 161) begin
      next_cycle();
      #1;
      chk("rr_quiet_busy", busy, 0);
      chk("rr_quiet_resp", {resp0_valid, resp1_valid}, 0);
    end
    next_cycle();
    req0_valid = 1; req1_valid = 1;
    req0_data = mk(0, 50); req1_data = mk(1, 50);
    #1;
    chk("rr_first_req0", req0_ready, 1);
    chk("rr_first_req1", req1_ready, 0);
    chk("rr_first_issue", {pipe_x, pipe_y, pipe_z}, mk(0, 50));
    next_cycle();
    req0_valid = 0; req1_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
